// File: rtl/mem_bus_arbiter.sv
// Two-master arbiter for the PicoRV32 native memory bus; grant is registered and held per transaction.
// Optional watchdog that completes hung transactions with an error response: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int PRIO_FIXED     = 0,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        m0_valid,
  output logic        m0_ready,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  output logic        m1_ready,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  input  logic        s_ready,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic [31:0] s_rdata,
  input  logic        err_clr,
  output logic        err_flag
);

  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e      state_q, state_d;
  logic        gnt_q, gnt_d;
  logic        last_q, last_d;
  logic        busy, sel_valid, done, tmo;
  logic [31:0] rsp_data;

  assign busy      = (state_q == BUSY);
  assign sel_valid = gnt_q ? m1_valid : m0_valid;

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;

  // Watchdog only fires while the master still requests; a slave ready in the limit cycle wins.
  assign tmo = busy && sel_valid && !s_ready && (cnt_q == CW'(TIMEOUT_CYCLES));

  always_comb begin
    cnt_d = '0;
    if (busy && !s_ready) cnt_d = cnt_q + CW'(1);
    err_d = err_q;
    if (tmo)          err_d = 1'b1;
    else if (err_clr) err_d = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_flag = err_q;
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  logic          unused_err_clr;

  assign unused_err_clr = err_clr;
  assign tmo            = 1'b0;
  assign err_flag       = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    last_d   = last_q;
    s_valid  = 1'b0;
    s_addr   = '0;
    s_wdata  = '0;
    s_wstrb  = '0;
    m0_ready = 1'b0;
    m1_ready = 1'b0;
    m0_rdata = '0;
    m1_rdata = '0;
    done     = 1'b0;
    rsp_data = '0;
    case (state_q)
      IDLE: begin
        if (m0_valid || m1_valid) begin
          state_d = BUSY;
          if (m0_valid && m1_valid) gnt_d = (PRIO_FIXED != 0) ? 1'b0 : ~last_q;
          else                      gnt_d = m1_valid;
        end
      end
      BUSY: begin
        s_valid  = sel_valid;
        s_addr   = gnt_q ? m1_addr  : m0_addr;
        s_wdata  = gnt_q ? m1_wdata : m0_wdata;
        s_wstrb  = gnt_q ? m1_wstrb : m0_wstrb;
        done     = s_ready || tmo;
        rsp_data = tmo ? ERR_RDATA : s_rdata;
        if (gnt_q) begin
          m1_ready = done;
          m1_rdata = done ? rsp_data : '0;
        end else begin
          m0_ready = done;
          m0_rdata = done ? rsp_data : '0;
        end
        // A master withdrawing its request without completion aborts silently.
        if (done) begin
          last_d  = gnt_q;
          state_d = IDLE;
        end else if (!sel_valid) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: round-robin and fixed-priority instances share stimulus,
// a transaction-level model checks every cycle, directed literals pin the model.
module tb_mem_bus_arbiter;

  localparam int TMO_CYC = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        resetn;
  logic        m0_valid, m1_valid, s_ready, err_clr;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata, s_rdata;
  logic [3:0]  m0_wstrb, m1_wstrb;

  logic [1:0]  sv, m0r, m1r, ef;
  logic [31:0] sa [2];
  logic [31:0] sw [2];
  logic [31:0] r0 [2];
  logic [31:0] r1 [2];
  logic [3:0]  ss [2];

  int errors = 0;
  int checks = 0;

  for (genvar p = 0; p < 2; p++) begin : g_dut
    mem_bus_arbiter #(.PRIO_FIXED(p), .TIMEOUT_CYCLES(TMO_CYC)) u_dut (
      .clk(clk), .resetn(resetn),
      .m0_valid(m0_valid), .m0_ready(m0r[p]), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(r0[p]),
      .m1_valid(m1_valid), .m1_ready(m1r[p]), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(r1[p]),
      .s_valid(sv[p]), .s_ready(s_ready), .s_addr(sa[p]), .s_wdata(sw[p]),
      .s_wstrb(ss[p]), .s_rdata(s_rdata),
      .err_clr(err_clr), .err_flag(ef[p])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transaction-level model: who owns the bus (-1 none), who won last, watchdog age, error flag.
  int owner [2] = '{-1, -1};
  int last  [2] = '{1, 1};
  int age   [2] = '{0, 0};
  bit err   [2] = '{1'b0, 1'b0};

  function automatic bit req(int g);
    return (g == 1) ? m1_valid : m0_valid;
  endfunction

  function automatic bit fire(int p);
    return TMO_EN && owner[p] >= 0 && !s_ready && req(owner[p]) && age[p] == TMO_CYC;
  endfunction

  logic        e_v, e_r0, e_r1, e_err;
  logic [31:0] e_a, e_w, e_d0, e_d1;
  logic [3:0]  e_s;
  bit          f;
  int          g;

  always @(negedge clk) begin
    for (int p = 0; p < 2; p++) begin
      g = owner[p];
      f = fire(p);
      e_v = 0; e_a = 0; e_w = 0; e_s = 0; e_r0 = 0; e_r1 = 0; e_d0 = 0; e_d1 = 0;
      e_err = resetn ? err[p] : 1'b0;
      if (resetn && g >= 0) begin
        e_v = req(g);
        e_a = (g == 1) ? m1_addr  : m0_addr;
        e_w = (g == 1) ? m1_wdata : m0_wdata;
        e_s = (g == 1) ? m1_wstrb : m0_wstrb;
        if (s_ready || f) begin
          if (g == 1) begin e_r1 = 1; e_d1 = f ? 32'hDEAD_BEEF : s_rdata; end
          else        begin e_r0 = 1; e_d0 = f ? 32'hDEAD_BEEF : s_rdata; end
        end
      end
      chk($sformatf("p%0d s_valid", p),  32'(sv[p]),  32'(e_v));
      chk($sformatf("p%0d s_addr", p),   sa[p],       e_a);
      chk($sformatf("p%0d s_wdata", p),  sw[p],       e_w);
      chk($sformatf("p%0d s_wstrb", p),  32'(ss[p]),  32'(e_s));
      chk($sformatf("p%0d m0_ready", p), 32'(m0r[p]), 32'(e_r0));
      chk($sformatf("p%0d m1_ready", p), 32'(m1r[p]), 32'(e_r1));
      chk($sformatf("p%0d m0_rdata", p), r0[p],       e_d0);
      chk($sformatf("p%0d m1_rdata", p), r1[p],       e_d1);
      chk($sformatf("p%0d err_flag", p), 32'(ef[p]),  32'(e_err));
      // Advance the model with the inputs the DUT will sample at the coming edge.
      if (!resetn) begin
        owner[p] = -1; last[p] = 1; age[p] = 0; err[p] = 0;
      end else begin
        if (f) err[p] = 1;
        else if (err_clr) err[p] = 0;
        if (g < 0) begin
          if (m0_valid && m1_valid) owner[p] = (p == 1) ? 0 : 1 - last[p];
          else if (m0_valid)        owner[p] = 0;
          else if (m1_valid)        owner[p] = 1;
          age[p] = 0;
        end else if (s_ready || f) begin
          last[p] = g; owner[p] = -1;
        end else if (!req(g)) begin
          owner[p] = -1;
        end else begin
          age[p]++;
        end
      end
    end
  end

  int c00, c01, c10, c11;

  initial begin
    resetn = 0; m0_valid = 0; m1_valid = 0; s_ready = 0; err_clr = 0;
    m0_addr = 0; m0_wdata = 0; m0_wstrb = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_rdata = 0;
    repeat (2) @(negedge clk);
    chk("rst s_valid", 32'(sv), 32'd0);
    chk("rst ready", 32'({m0r, m1r}), 32'd0);
    chk("rst err_flag", 32'(ef), 32'd0);
    tick(); resetn = 1;
    tick();

    // m0 single read, slave ready in the second BUSY cycle
    m0_valid = 1; m0_addr = 32'h0000_0100;
    @(negedge clk); chk("rd c0 s_valid", 32'(sv[0]), 32'd0);
    tick();
    @(negedge clk); chk("rd c1 s_valid", 32'(sv[0]), 32'd1);
    chk("rd c1 s_addr", sa[0], 32'h0000_0100);
    chk("rd c1 m0_ready", 32'(m0r[0]), 32'd0);
    tick(); s_ready = 1; s_rdata = 32'h1234_5678;
    @(negedge clk); chk("rd c2 m0_ready", 32'(m0r[0]), 32'd1);
    chk("rd c2 m0_rdata", r0[0], 32'h1234_5678);
    chk("rd c2 m1_ready", 32'(m1r[0]), 32'd0);
    tick(); m0_valid = 0; m0_addr = 0; s_ready = 0; s_rdata = 0;
    @(negedge clk); chk("rd c3 s_valid", 32'(sv[0]), 32'd0);

    // m1 write passthrough
    tick(); m1_valid = 1; m1_addr = 32'h0200_0004; m1_wdata = 32'hAABB_CCDD; m1_wstrb = 4'b0011;
    tick();
    @(negedge clk); chk("wr s_valid", 32'(sv[1]), 32'd1);
    chk("wr s_addr", sa[1], 32'h0200_0004);
    chk("wr s_wdata", sw[1], 32'hAABB_CCDD);
    chk("wr s_wstrb", 32'(ss[1]), 32'h3);
    chk("wr m1_ready low", 32'(m1r[1]), 32'd0);
    tick(); s_ready = 1;
    @(negedge clk); chk("wr m1_ready", 32'(m1r[1]), 32'd1);
    tick(); m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0; s_ready = 0;

    // fresh reset, then both masters request continuously with an always-ready slave
    resetn = 0; tick(); resetn = 1;
    m0_valid = 1; m1_valid = 1; m0_addr = 32'h10; m1_addr = 32'h20; s_ready = 1; s_rdata = 32'hCAFE_0000;
    c00 = 0; c01 = 0; c10 = 0; c11 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      c00 += int'(m0r[0]); c01 += int'(m1r[0]); c10 += int'(m0r[1]); c11 += int'(m1r[1]);
      if (i == 1) chk("rr first grant addr", sa[0], 32'h10);
      if (i == 3) chk("rr second grant addr", sa[0], 32'h20);
      tick();
    end
    chk("rr m0 completions", 32'(c00), 32'd2);
    chk("rr m1 completions", 32'(c01), 32'd2);
    chk("fixed m0 completions", 32'(c10), 32'd4);
    chk("fixed m1 completions", 32'(c11), 32'd0);
    m0_valid = 0;
    tick();
    @(negedge clk); chk("fixed m1 after m0 drop", 32'(m1r[1]), 32'd1);
    chk("fixed m1 rdata", r1[1], 32'hCAFE_0000);
    tick(); m1_valid = 0; s_ready = 0; s_rdata = 0; m0_addr = 0; m1_addr = 0;
    tick();

    // reset asserted while m0 owns the bus
    m0_valid = 1; m0_addr = 32'h300;
    tick(); s_ready = 1; s_rdata = 32'h77;
    #1 resetn = 0;
    #1;
    chk("midrst s_valid", 32'(sv), 32'd0);
    chk("midrst m0_ready", 32'(m0r), 32'd0);
    chk("midrst m0_rdata", r0[0], 32'd0);
    tick(); resetn = 1; m1_valid = 1;
    tick();
    @(negedge clk); chk("postrst tie m0_ready", 32'(m0r[0]), 32'd1);
    chk("postrst tie m1_ready", 32'(m1r[0]), 32'd0);
    tick(); m0_valid = 0; m1_valid = 0; s_ready = 0; s_rdata = 0; m0_addr = 0;
    tick();

`ifdef MEM_ARB_TIMEOUT_EN
    // hung slave: watchdog completes with an error response
    m0_valid = 1; m0_addr = 32'h400;
    for (int c = 1; c <= 5; c++) begin
      tick();
      @(negedge clk);
      if (c < 5) chk($sformatf("tmo c%0d m0_ready", c), 32'(m0r[0]), 32'd0);
    end
    chk("tmo m0_ready", 32'(m0r[0]), 32'd1);
    chk("tmo m0_rdata", r0[0], 32'hDEAD_BEEF);
    tick(); m0_valid = 0; err_clr = 1;
    @(negedge clk); chk("tmo err_flag set", 32'(ef[0]), 32'd1);
    tick(); err_clr = 0;
    @(negedge clk); chk("tmo err_flag cleared", 32'(ef[0]), 32'd0);
    // slave ready exactly in the limit cycle
    tick(); m0_valid = 1;
    for (int c = 1; c <= 4; c++) tick();
    tick(); s_ready = 1; s_rdata = 32'h1357_9BDF;
    @(negedge clk); chk("limit m0_ready", 32'(m0r[0]), 32'd1);
    chk("limit m0_rdata", r0[0], 32'h1357_9BDF);
    tick(); m0_valid = 0; s_ready = 0; s_rdata = 0;
    @(negedge clk); chk("limit err_flag", 32'(ef[0]), 32'd0);
`else
    // hung slave stalls the bus; err_clr has no effect
    m0_valid = 1; m0_addr = 32'h400;
    tick(); err_clr = 1;
    repeat (10) tick();
    @(negedge clk); chk("hung s_valid", 32'(sv[0]), 32'd1);
    chk("hung m0_ready", 32'(m0r[0]), 32'd0);
    chk("hung err_flag", 32'(ef[0]), 32'd0);
    err_clr = 0;
    tick(); s_ready = 1; s_rdata = 32'h2468_ACE0;
    @(negedge clk); chk("hung release m0_rdata", r0[0], 32'h2468_ACE0);
    tick(); m0_valid = 0; s_ready = 0; s_rdata = 0; m0_addr = 0;
`endif
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-master arbiter for the PicoRV32 native memory bus (valid/ready, 32-bit address and data, 4-bit wstrb). It shares one downstream slave port between the CPU (master 0) and a second bus master such as a DMA or debug engine (master 1). It sits between the masters and the SoC address decoder, which sees a single master. Grant is registered and held for a whole transaction. An optional watchdog completes hung transactions with an error response.

## Interface
Parameters:
- PRIO_FIXED, default 0: 0 = round-robin on ties; 1 = master 0 always wins ties.
- TIMEOUT_CYCLES, default 255: watchdog limit in cycles, minimum 1. Only used when MEM_ARB_TIMEOUT_EN is defined.

Ports:
- clk  in  1  single clock for the whole block.
- resetn  in  1  reset; asynchronous, active-low.
- m0_valid, m1_valid  in  1  master request; held until the matching ready.
- m0_ready, m1_ready  out  1  one-cycle transaction completion pulse.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write enables; 0 means read.
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  request to the slave.
- s_ready  in  1  slave completion.
- s_addr  out  32  address to the slave.
- s_wdata  out  32  write data to the slave.
- s_wstrb  out  4  byte enables to the slave.
- s_rdata  in  32  read data from the slave.
- err_clr  in  1  synchronous clear of err_flag.
- err_flag  out  1  sticky timeout indicator.

## Operation
- States: IDLE, BUSY. The registered grant `gnt` (0 or 1) and `last_gnt` record the current and most recent winner.
- IDLE transitions:
  - Only one mN_valid high: gnt = N, go to BUSY.
  - Both valid, PRIO_FIXED=0: gnt = !last_gnt.
  - Both valid, PRIO_FIXED=1: gnt = 0.
  - Neither valid: stay in IDLE.
- BUSY datapath:
  - s_valid = m[gnt]_valid.
  - s_addr, s_wdata and s_wstrb are muxed from m[gnt].
  - m[gnt]_ready = s_ready.
  - m[gnt]_rdata = s_rdata.
- BUSY exits:
  - On s_ready: last_gnt ← gnt, go to IDLE.
  - If m[gnt]_valid drops without s_ready (protocol violation): go to IDLE; last_gnt is unchanged and no ready is issued.
- Outputs outside BUSY:
  - s_valid = 0, s_addr, s_wdata and s_wstrb = 0.
  - In IDLE both mN_ready = 0. The non-granted mN_ready = 0 always.
  - mN_rdata = 0 unless its ready is high.
  - s_ready received in IDLE is ignored.
- Reset values: state IDLE, last_gnt = 1 (so master 0 wins the first tie), all outputs 0, err_flag 0.
- Reset asserted mid-transaction aborts it immediately. No ready is issued and the slave sees s_valid fall asynchronously.

## Timing
- Arbitration latency: a request sampled in IDLE at edge k drives s_valid during cycle k+1.
- If the slave is combinationally ready, the master ready comes 1 cycle after request assertion.
- There is always one IDLE cycle between transactions, so throughput is at most one transaction per 2 cycles.
- s_valid drops in the cycle after s_ready, which meets the slave's single-pulse expectation.
- The ready-to-master path is combinational from s_ready; there are no added register stages on data.

## Configuration
- MEM_ARB_TIMEOUT_EN defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on entry to BUSY and increments each BUSY cycle without s_ready.
  - When the count equals TIMEOUT_CYCLES and s_ready is low: pulse m[gnt]_ready with m[gnt]_rdata = 32'hDEAD_BEEF, set err_flag, go to IDLE, update last_gnt.
  - s_ready arriving in the same cycle as the limit wins: a normal completion, and err_flag is not set.
  - err_flag clears on err_clr, unless a timeout fires in the same cycle, in which case set wins.
- MEM_ARB_TIMEOUT_EN undefined:
  - No counter logic is built.
  - err_flag is tied to 0 and err_clr is ignored.
  - A hung slave stalls the bus indefinitely.

## Test plan
- m0 single read: m0_valid at cycle 0, addr 0x0000_0100; slave ready at cycle 2 with rdata 0x1234_5678 → s_valid during cycles 1-2, m0_ready pulses at cycle 2 with 0x1234_5678, m1_ready stays 0.
- Tie, round-robin (PRIO_FIXED=0), both masters continuously requesting and the slave always ready → grants alternate 0,1,0,1; first grant is 0 after reset; each master completes once per 4 cycles.
- Tie, PRIO_FIXED=1 with both requesting continuously → m0 completes every 2 cycles and m1 starves. Then drop m0_valid → m1 is granted on the next IDLE cycle.
- Write passthrough: m1 write, wstrb 4'b0011, wdata 0xAABB_CCDD, addr 0x0200_0004 → s_* carry exactly these values while s_valid; m1_ready follows s_ready.
- Reset mid-transaction: assert resetn low while BUSY for m0 → s_valid, m0_ready and m0_rdata are 0 immediately; after release the next tie grants m0.
- With MEM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=4, s_ready held low: m0 request → m0_ready at cycle 5 with rdata 0xDEAD_BEEF and err_flag=1; pulse err_clr → err_flag=0. Repeat with s_ready arriving in the limit cycle → normal data returned and err_flag stays 0.
